mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequencer for the stage-1 32-lane MAC array. It accepts one command (image base address, length) from the
//  processor-side bus, streams image words from image RAM and weight rows from weight ROM, and times the array's
//  start/stop strobes. It then pulses done once all 32 lane results are final.
//  Sits between the picoRV32 MMIO decode and the systolic MAC array.
// PARAMETERS
//  DATA_W  32  image/weight word width
//  ADDR_W  10  image RAM / weight ROM address width
//  LEN_W   10  element-count width (784 pixels max used)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       high only in IDLE
//  cmd_base   in   ADDR_W  image start address
//  cmd_len    in   LEN_W   number of elements N
//  img_rd     out  1       image RAM read strobe
//  img_addr   out  ADDR_W  image RAM address
//  img_rdata  in   DATA_W  image RAM data, valid 1 cycle after img_rd
//  wt_addr    out  ADDR_W  weight ROM row index (ROM latency 1, output feeds array w inputs)
//  mac_image  out  DATA_W  registered image word to the array
//  mac_start  out  1       first-product strobe to the array (array input is not registered)
//  mac_stop   out  1       freeze strobe to the array (array input is not registered)
//  busy       out  1       command in progress
//  done       out  1       1-cycle pulse: lane results final
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM=IDLE; counters cleared. Reset mid-run aborts silently.
//  FSM: IDLE -> FETCH on cmd_valid&cmd_ready (cycle 0). FETCH issues N reads, then -> DRAIN.
//   DRAIN waits for the tag pipe to empty, then -> DONE. DONE lasts 1 cycle, then -> IDLE.
//  Element k (0..N-1), relative to cycle 0:
//   img_rd=1, img_addr=cmd_base+k in cycle 1+k; img_rdata in cycle 2+k; mac_image=elem k in cycle 3+k.
//   wt_addr=k in cycle 3+k. The array registers the image and the ROM has latency 1,
//   so product k forms in cycle 4+k.
//  mac_start=1 only in cycle 4. mac_stop=1 only in cycle N+4.
//   done=1 in cycle N+5. busy=1 in cycles 1..N+5.
//  img_addr wraps modulo 2^ADDR_W (no error). mac_image holds its last value when idle.
//  N==0: no img_rd, no mac_start/stop; busy=1 and done=1 in cycle 1; back to IDLE in cycle 2.
//  N==1: mac_start (cycle 4) and mac_stop (cycle 5) are separate cycles; they never coincide.
//  cmd_valid while busy: ignored (cmd_ready=0). The command must be held until accepted.
//  Timing: a 3-stage tag pipe {vld,first,last} shifts alongside the data.
//   mac_start = first at stage 3. mac_stop = last at stage 3, delayed by 1 more cycle.
// CONFIGURATION
//  MAC_SEQ_ABORT_EN defined: adds input abort (1 bit).
//   abort=1 while busy: next cycle FSM=IDLE, img_rd=0, tag pipe flushed, no done.
//   mac_stop pulses 1 cycle iff mac_start was already issued. abort in IDLE is ignored.
//   abort and cmd accepted in the same cycle: command wins, abort is ignored.
//  Not defined: no abort port; a run always completes.
// STRUCTURE
//  mnist_pkg: FSM state enum (IDLE, FETCH, DRAIN, DONE), DATA_W/ADDR_W/LEN_W defaults, TAG_DEPTH=3 constant.
//  Sub-module mac_seq_tagpipe: TAG_DEPTH-stage {vld,first,last} shift register with synchronous flush input.
// TESTING
//  1. base=0x010, N=4 -> img_addr 0x010..0x013 in cycles 1-4; wt_addr 0..3 in cycles 3-6;
//     mac_start cycle 4; mac_stop cycle 8; done cycle 9.
//  2. N=0 -> done in cycle 1; img_rd, mac_start and mac_stop never asserted.
//  3. N=1 -> mac_start cycle 4, mac_stop cycle 5, done cycle 6. Lane result = w_k*im for a known ROM row.
//  4. base=0x3FE, N=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
//     A second cmd_valid during the run is not accepted until IDLE.
//  5. rst_n low at cycle 3 of an N=784 run -> all outputs 0 at once; a fresh N=2 command runs normally.
//  6. MAC_SEQ_ABORT_EN: abort at cycle 10 of N=784 -> mac_stop once, no done, cmd_ready=1 next cycle;
//     abort at cycle 2 (before mac_start) -> no mac_stop.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and defaults for the MAC sequencer: FSM state enum,
// bus width defaults and the tag pipe depth.
package mnist_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 10;
  localparam int TAG_DEPTH  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/mac_seq_tagpipe.sv
// TAG_DEPTH-stage {vld,first,last} shift register with sync flush.
// In: clk, rst_n, flush_i, vld_i/first_i/last_i. Out: per-stage tags.
module mac_seq_tagpipe
  import mnist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 vld_i,
  input  logic                 first_i,
  input  logic                 last_i,
  output logic [TAG_DEPTH-1:0] vld_o,
  output logic [TAG_DEPTH-1:0] first_o,
  output logic [TAG_DEPTH-1:0] last_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o   <= '0;
      first_o <= '0;
      last_o  <= '0;
    end else if (flush_i) begin
      vld_o   <= '0;
      first_o <= '0;
      last_o  <= '0;
    end else begin
      vld_o   <= {vld_o[TAG_DEPTH-2:0], vld_i};
      first_o <= {first_o[TAG_DEPTH-2:0], first_i};
      last_o  <= {last_o[TAG_DEPTH-2:0], last_i};
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 32-lane MAC array: command in, image/weight
// streaming out, start/stop/done strobes. Optional MAC_SEQ_ABORT_EN
// adds the abort input. Ports: cmd_*, img_*, wt_addr, mac_*, busy, done.
module mac_seq_ctrl
  import mnist_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef MAC_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [DATA_W-1:0] mac_image,
  output logic              mac_start,
  output logic              mac_stop,
  output logic              busy,
  output logic              done
);

  state_e              state_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic                rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                first_q;
  logic                last_q;
  logic                busy_q;
  logic                done_q;
  logic                rdy_q;
  logic [ADDR_W-1:0]   wt_q;
  logic [DATA_W-1:0]   img_q;
  logic                stop_q;
  logic                started_q;
  logic                accept;
  logic                kill;
  logic [TAG_DEPTH-1:0] tag_vld;
  logic [TAG_DEPTH-1:0] tag_first;
  logic [TAG_DEPTH-1:0] tag_last;

  assign accept = cmd_valid & rdy_q;

`ifdef MAC_SEQ_ABORT_EN
  // busy_q is low in IDLE, so an accepted command always beats abort
  assign kill = abort & busy_q;
`else
  assign kill = 1'b0;
`endif

  mac_seq_tagpipe u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (kill),
    .vld_i   (rd_q),
    .first_i (first_q),
    .last_i  (last_q),
    .vld_o   (tag_vld),
    .first_o (tag_first),
    .last_o  (tag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (kill) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            addr_q <= cmd_base;
            if (cmd_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              rd_q    <= 1'b1;
              first_q <= 1'b1;
              last_q  <= (cmd_len == LEN_W'(1));
            end
          end
        end
        FETCH: begin
          first_q <= 1'b0;
          if (last_q) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + LEN_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
            // next read is the final one when k+1 == N-1
            last_q <= (cnt_q + LEN_W'(2) == len_q);
          end
        end
        DRAIN: begin
          if (~|tag_vld) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q     <= '0;
      wt_q      <= '0;
      stop_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      if (tag_vld[0]) img_q <= img_rdata;
      if (accept) wt_q <= '0;
      else if (tag_vld[1]) wt_q <= wt_q + ADDR_W'(1);
      // an aborted run still owes the array a stop once started
      if (kill) stop_q <= started_q | tag_first[TAG_DEPTH-1];
      else stop_q <= tag_last[TAG_DEPTH-1];
      if (kill) started_q <= 1'b0;
      else if (tag_last[TAG_DEPTH-1]) started_q <= 1'b0;
      else if (tag_first[TAG_DEPTH-1]) started_q <= 1'b1;
    end
  end

  assign cmd_ready = rdy_q;
  assign img_rd    = rd_q;
  assign img_addr  = addr_q;
  assign wt_addr   = wt_q;
  assign mac_image = img_q;
  assign mac_start = tag_first[TAG_DEPTH-1];
  assign mac_stop  = stop_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed + random commands against a
// cycle-formula reference model, RAM/ROM and one MAC lane model.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_base;
  logic [9:0]  cmd_len;
  logic        abort;
  logic        img_rd;
  logic [9:0]  img_addr;
  logic [31:0] img_rdata;
  logic [9:0]  wt_addr;
  logic [31:0] mac_image;
  logic        mac_start;
  logic        mac_stop;
  logic        busy;
  logic        done;

  mac_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
`ifdef MAC_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .img_rd    (img_rd),
    .img_addr  (img_addr),
    .img_rdata (img_rdata),
    .wt_addr   (wt_addr),
    .mac_image (mac_image),
    .mac_start (mac_start),
    .mac_stop  (mac_stop),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem  [1024];
  logic [31:0] wrom [1024];

  always @(posedge clk)
    img_rdata <= img_rd ? mem[img_addr] : $urandom();

  logic [31:0] im_r, rom_q, acc, prod;
  logic        run;
  assign prod = im_r * rom_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_r <= '0; rom_q <= '0; acc <= '0; run <= 1'b0;
    end else begin
      im_r  <= mac_image;
      rom_q <= wrom[wt_addr];
      if (mac_start) begin
        acc <= prod; run <= 1'b1;
      end else if (mac_stop) run <= 1'b0;
      else if (run) acc <= acc + prod;
    end
  end

  int checks   = 0;
  int failures = 0;
  int rel = -1;
  int mB  = 0;
  int mN  = 0;
  bit model_idle = 1'b1;
  bit img_known  = 1'b1;
  logic [31:0] last_img = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int endc;
    bit act, dn;
    logic [31:0] s;
    endc = (mN == 0) ? 1 : mN + 5;
    if (rel > endc) rel = -1;
    act = (rel >= 1);
    dn  = act && rel == endc;
    chk("busy", busy, act);
    chk("cmd_ready", cmd_ready, !act);
    chk("done", done, dn);
    chk("img_rd", img_rd, act && mN > 0 && rel <= mN);
    chk("mac_start", mac_start, act && mN > 0 && rel == 4);
    chk("mac_stop", mac_stop, act && mN > 0 && rel == mN + 4);
    if (act && mN > 0 && rel <= mN)
      chk("img_addr", img_addr, (mB + rel - 1) % 1024);
    if (act && mN > 0 && rel >= 3 && rel <= mN + 2) begin
      chk("wt_addr", wt_addr, rel - 3);
      last_img  = mem[(mB + rel - 3) % 1024];
      img_known = 1'b1;
    end
    if (img_known) chk("mac_image", mac_image, last_img);
    if (dn && mN > 0) begin
      s = '0;
      for (int k = 0; k < mN; k++)
        s += mem[(mB + k) % 1024] * wrom[k];
      chk("lane", acc, s);
    end
    model_idle = !act;
  endtask

  task automatic step();
    if (cmd_valid && model_idle) begin
      mB = cmd_base; mN = cmd_len; rel = 0;
    end
    @(posedge clk); #1;
    if (rel >= 0) rel++;
    check_all();
  endtask

  task automatic issue(input int b, input int n);
    cmd_base = 10'(b); cmd_len = 10'(n); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_idle();
    int n = 0;
    do begin step(); n++; end while (!model_idle && n < 2000);
    if (!model_idle) begin
      failures++;
      $display("FAIL timeout obs=busy exp=idle");
    end
  endtask

  task automatic check_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", img_rd, 0);
    chk("rst_addr", img_addr, 0);
    chk("rst_wt", wt_addr, 0);
    chk("rst_img", mac_image, 0);
    chk("rst_start", mac_start, 0);
    chk("rst_stop", mac_stop, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = $urandom();
      wrom[i] = $urandom();
    end
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_base = '0; cmd_len = '0;
    #12;
    check_reset();
    rst_n = 1'b1;
    step(); step();

    issue(10'h010, 4);
    run_idle();
    issue($urandom_range(0, 1023), 0);
    run_idle();
    issue($urandom_range(0, 1023), 1);
    run_idle();

    issue(10'h3FE, 4);
    while (rel < 2) step();
    cmd_base = 10'h100; cmd_len = 10'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !(rel == 1 && mB == 'h100); i++)
      step();
    cmd_valid = 1'b0;
    run_idle();

    issue($urandom_range(0, 1023), 784);
    while (rel < 3) step();
    rst_n = 1'b0;
    #1;
    check_reset();
    rel = -1; last_img = '0; img_known = 1'b1; model_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    issue($urandom_range(0, 1023), 2);
    run_idle();

`ifdef MAC_SEQ_ABORT_EN
    issue($urandom_range(0, 1023), 784);
    while (rel < 10) step();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab1_stop", mac_stop, 1);
    chk("ab1_done", done, 0);
    chk("ab1_ready", cmd_ready, 1);
    chk("ab1_busy", busy, 0);
    chk("ab1_rd", img_rd, 0);
    rel = -1; img_known = 1'b0; model_idle = 1'b1;
    repeat (8) step();
    issue($urandom_range(0, 1023), 784);
    while (rel < 2) step();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab2_stop", mac_stop, 0);
    chk("ab2_ready", cmd_ready, 1);
    chk("ab2_busy", busy, 0);
    rel = -1; img_known = 1'b0; model_idle = 1'b1;
    repeat (8) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    issue($urandom_range(0, 1023), 3);
    run_idle();
`endif

    for (int t = 0; t < 10; t++) begin
      repeat ($urandom_range(0, 3)) step();
      issue($urandom_range(0, 1023), $urandom_range(0, 12));
      run_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
